meta_resolver: RTL and testbench

Central responder for metastability events raised by DFFx-style flip-flop cells in a netlist under analysis. Each cell raises a request when its sampled value is unresolved; `meta_resolver` arbitrates among cells, supplies a resolved data bit per a selectable policy, and completes a four-phase handshake with the requesting cell. It sits beside the DFFx array in the instrumented netlist and closes the request/resolve loop those cells open.

---
 rtl/meta_resolver.sv | 134 +++++++++++++
 tb/tb_meta_resolver.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/meta_resolver.sv
// meta_resolver: round-robin responder that hands a resolved bit to one requesting DFFx cell at a time.
// Grant registered one edge after M; 3-cycle minimum handshake; a cell that never acks is dropped after TIMEOUT+1 cycles.
module meta_resolver #(
  parameter int          N       = 4,
  parameter logic [15:0] SEED    = 16'hACE1,
  parameter int          TIMEOUT = 15
) (
  input  logic         CK,
  input  logic         RS,
  input  logic [N-1:0] M,
  input  logic [N-1:0] T,
  input  logic [1:0]   mode,
  output logic         rD,
  output logic [N-1:0] rV,
  output logic         busy,
  output logic         err,
  output logic [15:0]  count
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam int          GW       = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, OFFER, DRAIN} state_t;

  state_t         state;
  logic [GW-1:0]  ptr;
  logic [GW-1:0]  g;
  logic [15:0]    lfsr;
  logic [7:0]     wcnt;

  logic           pick_vld;
  logic [GW-1:0]  pick_idx;
  logic [N-1:0]   pick_oh;
  logic [GW:0]    j;
  logic           pol;

  function automatic logic [GW-1:0] inc_wrap(input logic [GW-1:0] v);
    if (v == GW'(N - 1)) return '0;
    return v + 1'b1;
  endfunction

  // Scan from the highest offset down so the last hit is the one nearest ptr.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    j        = '0;
    for (int k = N - 1; k >= 0; k--) begin
      j = {1'b0, ptr} + (GW + 1)'(k);
      if (j >= (GW + 1)'(N)) j = j - (GW + 1)'(N);
      if (M[j[GW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = j[GW-1:0];
      end
    end
  end

  always_comb begin
    pick_oh           = '0;
    pick_oh[pick_idx] = 1'b1;
  end

  // rD still holds the previously issued bit, which is what toggle inverts.
  always_comb begin
    case (mode)
      2'b00:   pol = lfsr[0];
      2'b01:   pol = 1'b0;
      2'b10:   pol = 1'b1;
      default: pol = ~rD;
    endcase
  end

  always_ff @(posedge CK or posedge RS) begin
    if (RS) begin
      state <= IDLE;
      ptr   <= '0;
      g     <= '0;
      lfsr  <= SEED_EFF;
      wcnt  <= '0;
      rD    <= 1'b0;
      rV    <= '0;
      busy  <= 1'b0;
      err   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_vld) begin
            g     <= pick_idx;
            rD    <= pol;
            rV    <= pick_oh;
            wcnt  <= '0;
            busy  <= 1'b1;
            state <= OFFER;
            if (mode == 2'b00)
              lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
          end
        end
        OFFER: begin
          if (T[g]) begin
            rV    <= '0;
            state <= DRAIN;
            if (count != 16'hFFFF) count <= count + 16'd1;
          end else if (!M[g]) begin
            rV    <= '0;
            ptr   <= inc_wrap(g);
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wcnt == 8'(TIMEOUT)) begin
            rV    <= '0;
            err   <= 1'b1;
            ptr   <= inc_wrap(g);
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        DRAIN: begin
          if (!T[g]) begin
            ptr   <= inc_wrap(g);
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          rV    <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_meta_resolver.sv
// Bench for meta_resolver: directed handshake scenarios plus a random phase, all checked each cycle
// against a behavioural model built from the resolution rules.
module tb_meta_resolver;

  localparam int N  = 4;
  localparam int TO = 3;

  logic        CK = 1'b0;
  logic        RS = 1'b0;
  logic [3:0]  M  = '0;
  logic [3:0]  T  = '0;
  logic [1:0]  mode = 2'b00;
  logic        rD;
  logic [3:0]  rV;
  logic        busy;
  logic        err;
  logic [15:0] count;

  int total = 0;
  int bad   = 0;

  // model state: phase 0 idle, 1 offering, 2 waiting for ack release
  int          m_phase, m_owner, m_ptr, m_wait;
  logic [15:0] m_lfsr, m_cnt;
  logic        m_rd, m_err;
  logic [3:0]  m_rv;

  meta_resolver #(.N(N), .SEED(16'hACE1), .TIMEOUT(TO)) dut (
    .CK(CK), .RS(RS), .M(M), .T(T), .mode(mode),
    .rD(rD), .rV(rV), .busy(busy), .err(err), .count(count)
  );

  always #5 CK = ~CK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit bit_of(input logic [3:0] v, input int i);
    return ((v >> i) & 4'b0001) != 4'b0000;
  endfunction

  task automatic m_reset();
    m_phase = 0; m_owner = 0; m_ptr = 0; m_wait = 0;
    m_lfsr = 16'hACE1; m_cnt = 16'h0000;
    m_rd = 1'b0; m_err = 1'b0; m_rv = 4'b0000;
  endtask

  task automatic m_step();
    if (m_phase == 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_phase == 0 && bit_of(M, idx)) begin
          case (mode)
            2'b00: begin
              m_rd = m_lfsr[0];
              m_lfsr = m_lfsr[0] ? ((m_lfsr >> 1) ^ 16'hB400) : (m_lfsr >> 1);
            end
            2'b01:   m_rd = 1'b0;
            2'b10:   m_rd = 1'b1;
            default: m_rd = !m_rd;
          endcase
          m_owner = idx;
          m_rv    = 4'(1 << idx);
          m_wait  = 0;
          m_phase = 1;
        end
      end
    end else if (m_phase == 1) begin
      if (bit_of(T, m_owner)) begin
        m_rv = 4'b0000;
        if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        m_phase = 2;
      end else if (!bit_of(M, m_owner)) begin
        m_rv = 4'b0000;
        m_ptr = (m_owner + 1) % N;
        m_phase = 0;
      end else if (m_wait == TO) begin
        m_rv = 4'b0000;
        m_err = 1'b1;
        m_ptr = (m_owner + 1) % N;
        m_phase = 0;
      end else begin
        m_wait++;
      end
    end else begin
      if (!bit_of(T, m_owner)) begin
        m_ptr = (m_owner + 1) % N;
        m_phase = 0;
      end
    end
  endtask

  task automatic cyc();
    @(posedge CK);
    if (!RS) m_step();
    @(negedge CK);
    check_eq("rV",    32'(rV),    32'(m_rv));
    check_eq("rD",    32'(rD),    32'(m_rd));
    check_eq("busy",  32'(busy),  32'(m_phase != 0));
    check_eq("err",   32'(err),   32'(m_err));
    check_eq("count", 32'(count), 32'(m_cnt));
  endtask

  // Assert reset between clock edges and confirm outputs clear before any edge.
  task automatic do_reset();
    M  = '0;
    T  = '0;
    RS = 1'b1;
    #1;
    m_reset();
    check_eq("rst_rV",    32'(rV),    32'h0);
    check_eq("rst_rD",    32'(rD),    32'h0);
    check_eq("rst_busy",  32'(busy),  32'h0);
    check_eq("rst_err",   32'(err),   32'h0);
    check_eq("rst_count", 32'(count), 32'h0);
    @(negedge CK);
    RS = 1'b0;
  endtask

  task automatic serve(input int exp_idx, input logic exp_rd);
    for (int w = 0; w < 8 && rV == 4'b0000; w++) cyc();
    check_eq("rr_grant", 32'(rV), 32'(1 << exp_idx));
    check_eq("rr_rd",    32'(rD), 32'(exp_rd));
    T = rV;
    cyc();
    check_eq("rr_drop", 32'(rV), 32'h0);
    T = '0;
    cyc();
  endtask

  initial begin
    int hi;
    logic [3:0] tn, mn;
    logic [2:0] tog_exp [3];
    m_reset();
    @(negedge CK);

    // LFSR policy: first bit is lsb of ACE1, the next one lsb of E270.
    do_reset();
    mode = 2'b00;
    M = 4'b0100;
    cyc();
    check_eq("lfsr_rv", 32'(rV), 32'h4);
    check_eq("lfsr_rd", 32'(rD), 32'h1);
    M = 4'b0000; T = 4'b0100;
    cyc();
    check_eq("lfsr_cnt", 32'(count), 32'h1);
    T = 4'b0000;
    cyc();
    M = 4'b0001;
    cyc();
    check_eq("lfsr_next_rd", 32'(rD), 32'h0);
    M = 4'b0000; T = 4'b0001;
    cyc();
    T = 4'b0000;
    cyc();

    // Round robin with every cell requesting.
    do_reset();
    mode = 2'b10;
    M = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      serve(n % 4, 1'b1);
      check_eq("rr_count", 32'(count), 32'(n + 1));
    end
    M = '0;
    cyc();

    // Toggle policy from reset.
    do_reset();
    mode = 2'b11;
    tog_exp[0] = 3'd1; tog_exp[1] = 3'd0; tog_exp[2] = 3'd1;
    for (int r = 0; r < 3; r++) begin
      M = 4'b0010;
      cyc();
      check_eq("tog_rd", 32'(rD), 32'(tog_exp[r]));
      M = 4'b0000; T = 4'b0010;
      cyc();
      T = 4'b0000;
      cyc();
    end

    // Timeout: cell 0 never acks, cell 1 waits behind it.
    do_reset();
    mode = 2'b01;
    M = 4'b0011;
    hi = 0;
    for (int c = 0; c < 12; c++) begin
      cyc();
      if (rV[0]) hi++;
      else if (hi > 0) break;
    end
    check_eq("to_cycles", 32'(hi),    32'(TO + 1));
    check_eq("to_err",    32'(err),   32'h1);
    check_eq("to_count",  32'(count), 32'h0);
    cyc();
    check_eq("to_next_grant", 32'(rV), 32'h2);
    M = 4'b0000; T = 4'b0010;
    cyc();
    T = 4'b0000;
    cyc();

    // Withdrawal, then reset while a grant is outstanding.
    do_reset();
    M = 4'b1000;
    cyc();
    check_eq("wd_grant", 32'(rV), 32'h8);
    M = 4'b0000;
    cyc();
    check_eq("wd_rv",    32'(rV),    32'h0);
    check_eq("wd_err",   32'(err),   32'h0);
    check_eq("wd_count", 32'(count), 32'h0);
    M = 4'b1000;
    cyc();
    T = 4'b1000;
    cyc();
    T = 4'b0000; M = 4'b0000;
    cyc();
    M = 4'b1000;
    cyc();
    check_eq("mid_offer_rv", 32'(rV), 32'h8);
    do_reset();

    // Saturation: preload the counter just below the ceiling.
    do_reset();
    mode = 2'b01;
    dut.count = 16'hFFFE;
    m_cnt = 16'hFFFE;
    for (int r = 0; r < 3; r++) begin
      M = 4'b0001;
      cyc();
      M = 4'b0000; T = 4'b0001;
      cyc();
      check_eq("sat_count", 32'(count), 32'hFFFF);
      T = 4'b0000;
      cyc();
    end

    // Random traffic with a cooperative-but-sloppy responder.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      if (c == 2000) do_reset();
      tn = T;
      mn = M;
      for (int i = 0; i < N; i++) begin
        logic [3:0] b;
        b = 4'(1 << i);
        if (bit_of(rV, i)) begin
          if ($urandom_range(3) != 0) tn = tn | b; else tn = tn & ~b;
        end else if (bit_of(tn, i)) begin
          if ($urandom_range(1) == 0) tn = tn & ~b;
        end else if ($urandom_range(15) == 0) begin
          tn = tn | b;
        end
        if (bit_of(mn, i)) begin
          if ($urandom_range(7) == 0) mn = mn & ~b;
        end else if ($urandom_range(3) == 0) begin
          mn = mn | b;
        end
      end
      T = tn;
      M = mn;
      if ($urandom_range(7) == 0) mode = 2'($urandom_range(3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
